// File: rtl/alu_result_writeback.sv
// ALU result writeback stage: captures a 64-bit ALU result and sequences it onto a
// 32-bit register-file write port (one beat for single-word ops, LO then HI for mul/div).
module alu_result_writeback #(
  parameter int unsigned          ADDR_W  = 5,
  parameter logic [ADDR_W-1:0]    LO_ADDR = 5'd16,
  parameter logic [ADDR_W-1:0]    HI_ADDR = 5'd17,
  parameter int unsigned          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [63:0]       rz,
  input  logic [ADDR_W-1:0] dest,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpMul  = 5'b00010;
  localparam logic [4:0] OpDiv  = 5'b00011;
  localparam logic [4:0] OpAnd  = 5'b00100;
  localparam logic [4:0] OpOr   = 5'b00101;
  localparam logic [4:0] OpShr  = 5'b00110;
  localparam logic [4:0] OpShra = 5'b00111;
  localparam logic [4:0] OpShl  = 5'b01000;
  localparam logic [4:0] OpRor  = 5'b01001;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpNeg  = 5'b01100;
  localparam logic [4:0] OpNot  = 5'b01101;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  function automatic logic op_known(input logic [4:0] op);
    logic known;
    case (op)
      OpAdd, OpSub, OpMul, OpDiv, OpAnd, OpOr, OpShr, OpShra,
      OpShl, OpRor, OpRol, OpNeg, OpNot: known = 1'b1;
      default:                           known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic logic op_wide(input logic [4:0] op);
    return (op == OpMul) || (op == OpDiv);
  endfunction

  state_e              state_q, state_d;
  logic [63:0]         z_q;
  logic [4:0]          op_q;
  logic [ADDR_W-1:0]   dest_q;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic last_beat;
  logic accept;
  logic accept_known;
  logic beat_done;
  logic op_done;

  // Final beat of the held op; completing it frees the capture registers this cycle.
  assign last_beat    = ((state_q == StBeat0) && !op_wide(op_q)) || (state_q == StBeat1);
  assign in_ready     = reset && ((state_q == StIdle) || (last_beat && wb_ready));
  assign accept       = in_valid && in_ready;
  assign accept_known = accept && op_known(opcode);
  assign beat_done    = wb_valid && wb_ready;
  assign op_done      = beat_done && last_beat;

  always_comb begin
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    case (state_q)
      StBeat0: begin
        wb_valid = 1'b1;
        if (op_q == OpMul) begin
          wb_addr = LO_ADDR;
          wb_data = z_q[31:0];
        end else if (op_q == OpDiv) begin
          // Quotient lives in the upper half of the divider result.
          wb_addr = LO_ADDR;
          wb_data = z_q[63:32];
        end else begin
          wb_addr = dest_q;
          wb_data = z_q[31:0];
        end
      end
      StBeat1: begin
        wb_valid = 1'b1;
        wb_addr  = HI_ADDR;
        wb_data  = (op_q == OpMul) ? z_q[63:32] : z_q[31:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = accept && !op_known(opcode);
    count_d   = op_done ? count_q + CNT_W'(1) : count_q;
    case (state_q)
      StIdle: begin
        if (accept_known) state_d = StBeat0;
      end
      StBeat0: begin
        if (wb_ready) begin
          if (op_wide(op_q))     state_d = StBeat1;
          else if (accept_known) state_d = StBeat0;
          else                   state_d = StIdle;
        end
      end
      StBeat1: begin
        if (wb_ready) state_d = accept_known ? StBeat0 : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      z_q       <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      if (accept) begin
        z_q    <= rz;
        op_q   <= opcode;
        dest_q <= dest;
      end
    end
  end

  assign illegal_op = illegal_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench: stimulus pushes hand-computed write beats into a queue; a monitor
// pops and compares each beat the DUT hands off to the register file.
module tb_alu_result_writeback;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [63:0] rz;
  logic [4:0]  dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal_op;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [36:0] exp_q[$];

  alu_result_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rz        (rz),
    .dest      (dest),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .illegal_op(illegal_op),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake under reset does not take effect, so it is ignored.
  always @(negedge clk) begin
    if (reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h_%0h expected=none", wb_addr, wb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("beat_addr", 64'(wb_addr), 64'(e[36:32]));
        check("beat_data", 64'(wb_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for in_ready, queue its expected beats, take the edge.
  task automatic issue(input logic [4:0] op, input logic [63:0] v, input logic [4:0] d,
                       input int nb, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, output int waits);
    in_valid = 1'b1;
    opcode   = op;
    rz       = v;
    dest     = d;
    #1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      step();
      waits++;
    end
    if (waits == 20) check("issue_timeout", 64'(in_ready), 64'd1);
    if (nb > 0) exp_q.push_back({a0, d0});
    if (nb > 1) exp_q.push_back({a1, d1});
    step();
  endtask

  int w;
  int total_waits;
  int c0;
  logic [4:0]  held_addr;
  logic [31:0] held_data;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    opcode   = '0;
    rz       = '0;
    dest     = '0;
    wb_ready = 1'b1;
    #1;
    check("in_ready_in_reset_t0", 64'(in_ready), 64'd0);
    step();
    step();
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_illegal", 64'(illegal_op), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // add: single beat one cycle after accept
    issue(5'b00000, 64'h7, 5'd3, 1, 5'd3, 32'h7, 5'd0, 32'h0, w);
    in_valid = 1'b0;
    check("add_latency_valid", 64'(wb_valid), 64'd1);
    check("add_addr_direct", 64'(wb_addr), 64'd3);
    step();
    check("add_count", 64'(op_count), 64'd1);
    check("add_idle_valid", 64'(wb_valid), 64'd0);

    // mul: LO then HI; no accept during BEAT0
    issue(5'b00010, 64'h0000_0001_8000_0000, 5'd0, 2, 5'd16, 32'h8000_0000, 5'd17,
          32'h0000_0001, w);
    in_valid = 1'b0;
    check("mul_beat0_in_ready", 64'(in_ready), 64'd0);
    step();
    check("mul_beat1_in_ready", 64'(in_ready), 64'd1);
    check("mul_beat1_addr", 64'(wb_addr), 64'd17);
    step();
    check("mul_count", 64'(op_count), 64'd2);

    // div 17/3: quotient to LO, remainder to HI
    issue(5'b00011, {32'd5, 32'd2}, 5'd0, 2, 5'd16, 32'd5, 5'd17, 32'd2, w);
    in_valid = 1'b0;
    step();
    step();
    check("div_count", 64'(op_count), 64'd3);

    // Back-to-back single-word ops: one per cycle
    c0 = cyc;
    total_waits = 0;
    issue(5'b00001, 64'hFFFF_FFFF_1234_5678, 5'd4, 1, 5'd4, 32'h1234_5678, 5'd0, 32'h0, w);
    total_waits += w;
    issue(5'b00100, 64'h0000_0000_0000_0F0F, 5'd5, 1, 5'd5, 32'h0000_0F0F, 5'd0, 32'h0, w);
    total_waits += w;
    issue(5'b01000, 64'h0000_0000_8000_0001, 5'd31, 1, 5'd31, 32'h8000_0001, 5'd0, 32'h0, w);
    total_waits += w;
    issue(5'b01101, 64'h0000_0001_FFFF_FFFE, 5'd0, 1, 5'd0, 32'hFFFF_FFFE, 5'd0, 32'h0, w);
    total_waits += w;
    check("b2b_waits", 64'(total_waits), 64'd0);
    check("b2b_cycles", 64'(cyc - c0), 64'd4);
    in_valid = 1'b0;
    step();
    check("b2b_count", 64'(op_count), 64'd7);

    // Stall: beat must hold while wb_ready is low, next op blocked
    issue(5'b00101, 64'h0000_0000_CAFE_F00D, 5'd9, 1, 5'd9, 32'hCAFE_F00D, 5'd0, 32'h0, w);
    wb_ready = 1'b0;
    opcode   = 5'b01011;
    rz       = 64'h42;
    dest     = 5'd10;
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    held_addr = wb_addr;
    held_data = wb_data;
    check("stall_held_addr", 64'(held_addr), 64'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 64'(wb_valid), 64'd1);
      check("stall_addr", 64'(wb_addr), 64'd9);
      check("stall_data", 64'(wb_data), 64'(held_data));
      check("stall_in_ready_hold", 64'(in_ready), 64'd0);
    end
    check("stall_count", 64'(op_count), 64'd7);
    wb_ready = 1'b1;
    issue(5'b01011, 64'h42, 5'd10, 1, 5'd10, 32'h42, 5'd0, 32'h0, w);
    in_valid = 1'b0;
    step();
    check("stall_done_count", 64'(op_count), 64'd9);

    // Unknown opcode: dropped, one-cycle illegal pulse
    issue(5'b01010, 64'h55, 5'd7, 0, 5'd0, 32'h0, 5'd0, 32'h0, w);
    in_valid = 1'b0;
    check("illegal_pulse", 64'(illegal_op), 64'd1);
    check("illegal_no_beat", 64'(wb_valid), 64'd0);
    step();
    check("illegal_pulse_end", 64'(illegal_op), 64'd0);
    check("illegal_no_beat2", 64'(wb_valid), 64'd0);
    check("illegal_count", 64'(op_count), 64'd9);

    // Reset during BEAT1 of a mul: LO already written, HI must never appear
    issue(5'b00010, 64'h0000_00AB_0000_00CD, 5'd0, 1, 5'd16, 32'h0000_00CD, 5'd0, 32'h0, w);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    step();
    check("rst_mid_valid", 64'(wb_valid), 64'd0);
    check("rst_mid_count", 64'(op_count), 64'd0);
    check("rst_mid_addr", 64'(wb_addr), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_beat", 64'(wb_valid), 64'd0);
    end
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    issue(5'b00000, 64'hFFFF_FFFF_0000_0009, 5'd1, 1, 5'd1, 32'h9, 5'd0, 32'h0, w);
    in_valid = 1'b0;
    step();
    check("post_rst_count", 64'(op_count), 64'd1);

    step();
    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Stage directly downstream of the ALU: captures the 64-bit RZ result with its opcode and destination index.
- Sequences the captured result onto the register file's 32-bit write port.
- Single-word ops (add/sub/logic/shift/rotate/neg/not): one write beat to the destination register.
- mul/div: two beats, LO first, then HI. Valid/ready handshake on both sides; supports back-to-back ops without bubbles.

Parameters:
ADDR_W, 5, width of register write address
LO_ADDR, 5'd16, write address of the LO register
HI_ADDR, 5'd17, write address of the HI register
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge)
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept a result this cycle
opcode  input  5  ALU opcode that produced rz
rz  input  64  ALU result
dest  input  ADDR_W  destination register index for single-word ops
wb_valid  output  1  write beat valid
wb_ready  input  1  register file accepts beat
wb_addr  output  ADDR_W  write address
wb_data  output  32  write data
illegal_op  output  1  one-cycle pulse: unknown opcode accepted and dropped
op_count  output  CNT_W  completed operations, wraps

Behaviour:
- Opcodes: add 00000, sub 00001, mul 00010, div 00011, and 00100, or 00101, shr 00110, shra 00111, shl 01000, ror 01001, rol 01011, neg 01100, not 01101. Wide ops are mul and div; all other listed codes are single-word ops. Any other code is unknown.
- Accept = in_valid && in_ready. On accept, latch z_q <= rz, op_q <= opcode, dest_q <= dest.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE: wb_valid=0. On accept of a known op -> BEAT0. On accept of an unknown op: stay IDLE, pulse illegal_op next cycle, no beat, op_count unchanged.
  - BEAT0: wb_valid=1.
    - Single-word op: wb_addr=dest_q, wb_data=z_q[31:0].
    - mul: wb_addr=LO_ADDR, wb_data=z_q[31:0].
    - div: wb_addr=LO_ADDR, wb_data=z_q[63:32] (quotient).
    - On wb_ready: wide op -> BEAT1. Single-word op completes: -> BEAT0 if a known op is accepted the same cycle, else -> IDLE.
  - BEAT1: wb_valid=1, wb_addr=HI_ADDR.
    - mul: wb_data=z_q[63:32].
    - div: wb_data=z_q[31:0] (remainder).
    - On wb_ready the op completes, with the same next-state rule as single-word completion.
- in_ready = reset && (state==IDLE || (last beat && wb_ready)). The last beat is BEAT0 for single-word ops and BEAT1 for wide ops. This is a combinational path from wb_ready to in_ready. No accept in BEAT0 of a wide op.
- Same-cycle completion and accept: the new result overwrites z_q/op_q/dest_q. The finishing beat uses the old values, which are presented in that same cycle.
- Stall: while wb_valid && !wb_ready, wb_addr and wb_data hold stable and the state holds.
- op_count increments by 1 on each op completion (final beat handshake) and wraps from all-ones to 0.
- Latency: accept in cycle N gives the first beat valid in cycle N+1. Minimum 1 cycle/op for single-word ops, 2 for wide.
- Reset (reset==0 at an edge):
  - state=IDLE; z_q, op_q, dest_q = 0.
  - wb_valid=0, wb_addr=0, wb_data=0, illegal_op=0, op_count=0.
  - in_ready=0 while reset is low.
  - Reset mid-op aborts any remaining beat; no partial HI write is issued afterwards.

Test Plan:
- add: opcode 00000, rz=64'h0000_0000_0000_0007, dest=3, wb_ready=1 -> one beat, addr 3, data 32'h7, one cycle after accept; op_count=1.
- mul: opcode 00010, rz=64'h0000_0001_8000_0000 -> beat addr 16 data 32'h8000_0000, next cycle addr 17 data 32'h0000_0001; in_ready low during BEAT0.
- div: opcode 00011, rz={32'd5,32'd2} (17/3) -> addr 16 data 5, then addr 17 data 2.
- Back-to-back: 4 single-word ops with in_valid held high, wb_ready=1 -> 4 consecutive beats, no bubbles, op_count=4. Then wb_ready low 3 cycles mid-stream -> wb_data/wb_addr stable, in_ready low.
- Unknown opcode 01010 -> accepted, no wb_valid, illegal_op high exactly one cycle, op_count unchanged.
- reset low during BEAT1 of a mul -> next cycle wb_valid=0, op_count=0, no HI write. After release, in_ready=1 and a fresh add completes normally.
